// File: rtl/ex_case_decode_pipe.sv
// Address-decoded data transform: the top two address bits select one of four
// operations, and the result comes out PIPE cycles later with valid, region and miss flags.
module ex_case_decode_pipe #(
    parameter int DW    = 10,
    parameter int AW    = 8,
    parameter int OW    = 8,
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             i_vld,
    input  logic [DW-1:0]    i_data,
    input  logic [AW-1:0]    i_addr,
    input  logic [1:0]       i_mode,
    input  logic             i_cnt_clr,
    output logic             o_dv,
    output logic [OW-1:0]    o_data,
    output logic [1:0]       o_region,
    output logic             o_miss,
    output logic [CNT_W-1:0] o_hit_cnt
);

    localparam logic [1:0] MODE_BYP  = 2'b01;
    localparam logic [1:0] MODE_MASK = 2'b10;

    // Clamp to all ones when any bit above the output width is set.
    function automatic logic [OW-1:0] f_sat(input logic [DW-1:0] data);
        logic [DW-1:0] v_hi;
        v_hi = data >> OW;
        if (v_hi != '0) begin
            f_sat = '1;
        end else begin
            f_sat = data[OW-1:0];
        end
    endfunction

    function automatic logic [OW-1:0] f_xform(input logic [DW-1:0] data,
                                              input logic [AW-1:0] addr,
                                              input logic [1:0]    mode);
        logic [OW-1:0] v_low;
        v_low   = data[OW-1:0];
        f_xform = v_low;
        if (mode != MODE_BYP) begin
            case (addr[AW-1:AW-2])
                2'd0:    f_xform = v_low;
                2'd1:    f_xform = ~v_low;
                2'd2:    f_xform = v_low + OW'(addr);
                default: f_xform = f_sat(data);
            endcase
        end
    endfunction

    logic [1:0]    w_rgn;
    logic          w_mask;
    logic          w_dv;
    logic          w_miss;
    logic [OW-1:0] w_dat;

    assign w_rgn  = i_addr[AW-1:AW-2];
    assign w_mask = (i_mode == MODE_MASK) && (w_rgn == 2'd3);
    assign w_dv   = i_vld && !w_mask;
    assign w_miss = i_vld && w_mask;
    assign w_dat  = f_xform(i_data, i_addr, i_mode);

    logic [PIPE-1:0] r_vld_p;
    logic [PIPE-1:0] r_miss_p;
    logic [OW-1:0]   r_dat_p [PIPE];
    logic [1:0]      r_rgn_p [PIPE];
    logic [CNT_W-1:0] r_hit_cnt;

    // Stage 0 captures the transformed sample; later stages shift it toward the output.
    // Data only advances alongside a valid, so the last stage holds the most recent result.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p  <= '0;
            r_miss_p <= '0;
            for (int k = 0; k < PIPE; k++) begin
                r_dat_p[k] <= '0;
                r_rgn_p[k] <= '0;
            end
        end else begin
            r_vld_p[0]  <= w_dv;
            r_miss_p[0] <= w_miss;
            if (w_dv) begin
                r_dat_p[0] <= w_dat;
                r_rgn_p[0] <= w_rgn;
            end
            for (int k = 1; k < PIPE; k++) begin
                r_vld_p[k]  <= r_vld_p[k-1];
                r_miss_p[k] <= r_miss_p[k-1];
                if (r_vld_p[k-1]) begin
                    r_dat_p[k] <= r_dat_p[k-1];
                    r_rgn_p[k] <= r_rgn_p[k-1];
                end
            end
        end
    end

    // Output stage: count presented results, saturating; a clear beats an increment.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_hit_cnt <= '0;
        end else if (r_vld_p[PIPE-1] && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign o_dv      = r_vld_p[PIPE-1];
    assign o_miss    = r_miss_p[PIPE-1];
    assign o_data    = r_dat_p[PIPE-1];
    assign o_region  = r_rgn_p[PIPE-1];
    assign o_hit_cnt = r_hit_cnt;

endmodule
